// File: rtl/button_cmd_arbiter.sv
// Purpose : debounce raw buttons into pending requests and issue them one at a time by round-robin.
// Latency : raw edge -> debounced after DEBOUNCE_CYCLES+2 edges, pending +1, cmd_valid +1 more.
// Backpres: cmd_valid/cmd_id hold until cmd_ready. Meanwhile, further presses stay queued in pending, or set overrun.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   reset_     asynchronous, active-high reset
//   button     raw asynchronous buttons, 1 = pressed
//   cmd_valid  command offered to the state machine
//   cmd_id     index of the granted button, meaningful while cmd_valid
//   cmd_ready  state machine accepts the command this cycle
//   pending    per-button request waiting (LED drive)
//   overrun    sticky per-button flag: a press was lost because a request was already pending
module button_cmd_arbiter #(
  parameter int N_BTN           = 6,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ID_W            = 3
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [N_BTN-1:0] button,
  output logic             cmd_valid,
  output logic [ID_W-1:0]  cmd_id,
  input  logic             cmd_ready,
  output logic [N_BTN-1:0] pending,
  output logic [N_BTN-1:0] overrun
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The counter never stores DEBOUNCE_CYCLES. The flip happens on the edge where it would reach it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state, state_nxt;
  logic [N_BTN-1:0] sync1, sync2;
  logic [N_BTN-1:0] deb, deb_q;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] grant_clr;
  logic             handshake;
  logic [ID_W-1:0]  last_grant;
  logic             sel_found;
  logic [ID_W-1:0]  sel_id;
  logic [ID_W-1:0]  idx_v;

  // Two-flop synchroniser. Only sync2 is seen by the rest of the logic.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // Per-button debounce. Any cycle that matches the debounced level restarts the count.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      deb <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CNT_LAST) begin
            deb[i] <= ~deb[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Registered rising-edge detect on the debounced level. Release produces no event.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) deb_q <= '0;
    else        deb_q <= deb;
  end

  assign press     = deb & ~deb_q;
  assign handshake = cmd_valid & cmd_ready;

  always_comb begin
    grant_clr = '0;
    for (int i = 0; i < N_BTN; i++) begin
      grant_clr[i] = handshake && (cmd_id == ID_W'(i));
    end
  end

  // A press that coincides with the handshake of the same button re-arms its request without flagging overrun.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~grant_clr) | press;
      overrun <= overrun | (press & pending & ~grant_clr);
    end
  end

  // Round-robin search: the first pending bit, starting just above last_grant and wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx_v     = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx_v = ID_W'((int'(last_grant) + k) % N_BTN);
      if (!sel_found && pending[idx_v]) begin
        sel_found = 1'b1;
        sel_id    = idx_v;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = OFFER;
      OFFER:   if (handshake) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cmd_valid = (state == OFFER);
  end

  // cmd_id is captured once on entry to OFFER and stays frozen there. Presses during the offer cannot disturb it.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      cmd_id     <= '0;
      last_grant <= ID_W'(N_BTN - 1);
    end else begin
      if (state == IDLE && sel_found) cmd_id <= sel_id;
      if (handshake)                  last_grant <= cmd_id;
    end
  end

endmodule

// File: tb/tb_button_cmd_arbiter.sv
module tb_button_cmd_arbiter;

  logic       clk;
  logic       reset_;
  logic [5:0] button;
  logic       cmd_valid;
  logic [2:0] cmd_id;
  logic       cmd_ready;
  logic [5:0] pending;
  logic [5:0] overrun;

  int checks = 0;
  int errors = 0;

  button_cmd_arbiter #(
    .N_BTN(6),
    .DEBOUNCE_CYCLES(4),
    .ID_W(3)
  ) dut (
    .clk(clk),
    .reset_(reset_),
    .button(button),
    .cmd_valid(cmd_valid),
    .cmd_id(cmd_id),
    .cmd_ready(cmd_ready),
    .pending(pending),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end in time");
    $fatal(1);
  end

  typedef struct {
    logic [5:0] button;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_id;
    logic [5:0] exp_pending;
    logic [5:0] exp_overrun;
  } vec_t;

  vec_t tbl [14];

  // Advance past the next rising edge and settle, so samples sit away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic exp_out(input string name, input logic v, input logic [2:0] id,
                         input logic [5:0] pend, input logic [5:0] ovr);
    chk({name, "_valid"}, cmd_valid, v);
    if (v) chk({name, "_id"}, cmd_id, id);
    chk({name, "_pending"}, pending, pend);
    chk({name, "_overrun"}, overrun, ovr);
  endtask

  task automatic do_reset();
    reset_ = 1'b1;
    step();
    step();
    reset_ = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (cmd_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic seen;

  initial begin
    button    = '0;
    cmd_ready = 1'b0;
    reset_    = 1'b0;
    #1 reset_ = 1'b1;
    #1;
    exp_out("reset", 1'b0, 3'd0, 6'h00, 6'h00);
    chk("reset_id", cmd_id, 3'd0);
    step();
    step();
    reset_ = 1'b0;

    // Test 1: button[2] held, cmd_ready=1. Entry n holds the expected state after edge n.
    for (int n = 0; n < 14; n++) begin
      tbl[n] = '{button: 6'b000100, ready: 1'b1, exp_valid: 1'b0, exp_id: 3'd0,
                 exp_pending: 6'h00, exp_overrun: 6'h00};
    end
    tbl[6].exp_pending = 6'h04;
    tbl[7].exp_valid   = 1'b1;
    tbl[7].exp_id      = 3'd2;
    tbl[7].exp_pending = 6'h04;
    for (int n = 0; n < 14; n++) begin
      button    = tbl[n].button;
      cmd_ready = tbl[n].ready;
      step();
      exp_out($sformatf("t1_e%0d", n), tbl[n].exp_valid, tbl[n].exp_id,
              tbl[n].exp_pending, tbl[n].exp_overrun);
    end
    repeat (6) step();
    button = '0;
    repeat (10) step();

    // Test 2: a 3-cycle glitch never passes the debouncer.
    do_reset();
    cmd_ready = 1'b1;
    button    = 6'b000001;
    for (int c = 0; c < 15; c++) begin
      if (c == 3) button = '0;
      step();
      chk($sformatf("t2_valid_c%0d", c), cmd_valid, 1'b0);
      chk($sformatf("t2_pending_c%0d", c), pending, 6'h00);
    end

    // Test 3: round-robin order 1,4, then 5,0 after last grant 4.
    do_reset();
    cmd_ready = 1'b1;
    button    = 6'b010010;
    repeat (7) step();
    exp_out("t3a_e6", 1'b0, 3'd0, 6'h12, 6'h00);
    step(); exp_out("t3a_e7", 1'b1, 3'd1, 6'h12, 6'h00);
    step(); exp_out("t3a_e8", 1'b0, 3'd0, 6'h10, 6'h00);
    step(); exp_out("t3a_e9", 1'b1, 3'd4, 6'h10, 6'h00);
    step(); exp_out("t3a_e10", 1'b0, 3'd0, 6'h00, 6'h00);
    button = '0;
    repeat (10) step();
    button = 6'b100001;
    repeat (7) step();
    exp_out("t3b_e6", 1'b0, 3'd0, 6'h21, 6'h00);
    step(); exp_out("t3b_e7", 1'b1, 3'd5, 6'h21, 6'h00);
    step(); exp_out("t3b_e8", 1'b0, 3'd0, 6'h01, 6'h00);
    step(); exp_out("t3b_e9", 1'b1, 3'd0, 6'h01, 6'h00);
    step(); exp_out("t3b_e10", 1'b0, 3'd0, 6'h00, 6'h00);
    button = '0;
    repeat (10) step();

    // Test 4: a long stall with a re-press of the pending button sets overrun.
    do_reset();
    cmd_ready = 1'b0;
    button    = 6'b001000;
    repeat (8) step();
    exp_out("t4_offer", 1'b1, 3'd3, 6'h08, 6'h00);
    for (int c = 0; c < 30; c++) begin
      if (c == 1)  button = '0;
      if (c == 10) button = 6'b001000;
      step();
      chk($sformatf("t4_hold_valid_c%0d", c), cmd_valid, 1'b1);
      chk($sformatf("t4_hold_id_c%0d", c), cmd_id, 3'd3);
    end
    chk("t4_overrun_set", overrun, 6'h08);
    chk("t4_pending_held", pending, 6'h08);
    cmd_ready = 1'b1;
    step();
    exp_out("t4_hs", 1'b0, 3'd0, 6'h00, 6'h08);
    step();
    exp_out("t4_after", 1'b0, 3'd0, 6'h00, 6'h08);
    button = '0;
    repeat (8) step();

    // Test 5: asynchronous reset mid-offer drops the command and clears the flags at once.
    cmd_ready = 1'b0;
    button    = 6'b000010;
    wait_valid(20, seen);
    chk("t5_valid_seen", seen, 1'b1);
    chk("t5_id", cmd_id, 3'd1);
    chk("t5_overrun_before", overrun, 6'h08);
    #3 reset_ = 1'b1;
    #1;
    exp_out("t5_async", 1'b0, 3'd0, 6'h00, 6'h00);
    button = '0;
    step();
    step();
    reset_ = 1'b0;
    cmd_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      chk($sformatf("t5_quiet_valid_c%0d", c), cmd_valid, 1'b0);
      chk($sformatf("t5_quiet_pend_c%0d", c), pending, 6'h00);
    end

    // Test 6: a new press landing on the handshake edge of the same button re-queues it without overrun.
    do_reset();
    cmd_ready = 1'b0;
    button    = 6'b100000;
    repeat (8) step();
    exp_out("t6_offer", 1'b1, 3'd5, 6'h20, 6'h00);
    button = '0;
    repeat (8) step();
    button = 6'b100000;
    repeat (6) step();
    exp_out("t6_pre_hs", 1'b1, 3'd5, 6'h20, 6'h00);
    cmd_ready = 1'b1;
    step();
    exp_out("t6_hs", 1'b0, 3'd0, 6'h20, 6'h00);
    step();
    exp_out("t6_second", 1'b1, 3'd5, 6'h20, 6'h00);
    step();
    exp_out("t6_done", 1'b0, 3'd0, 6'h00, 6'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
